// File: rtl/w_order_scheduler_if.sv
// Signal bundle between the AW arbiter / W masters and the W-order scheduler.
// Beat rule: a W beat transfers on a rising edge where the granted master's mst_wvalid_i and bus_wready_i are both 1; valid never waits on ready.
interface w_order_scheduler_if #(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int LOG_M = (M > 1) ? $clog2(M) : 1,
  parameter int LOG_N = (N > 1) ? $clog2(N) : 1
);
  logic                 aw_fire_i;
  logic [LOG_M-1:0]     aw_src_i;
  logic [LOG_N-1:0]     aw_dst_i;
  logic [N-1:0]         aw_full_o;
  logic [M-1:0]         mst_wvalid_i;
  logic [M*LOG_N-1:0]   mst_wdst_i;
  logic [M-1:0]         mst_wlast_i;
  logic                 bus_wready_i;
  logic [M-1:0]         w_grant_o;
  logic [LOG_M-1:0]     w_src_o;
  logic [LOG_N-1:0]     w_dst_o;
  logic                 w_busy_o;
  logic                 err_o;

  modport master (
    output aw_fire_i, aw_src_i, aw_dst_i, mst_wvalid_i, mst_wdst_i, mst_wlast_i, bus_wready_i,
    input  aw_full_o, w_grant_o, w_src_o, w_dst_o, w_busy_o, err_o
  );

  modport slave (
    input  aw_fire_i, aw_src_i, aw_dst_i, mst_wvalid_i, mst_wdst_i, mst_wlast_i, bus_wready_i,
    output aw_full_o, w_grant_o, w_src_o, w_dst_o, w_busy_o, err_o
  );
endinterface

// File: rtl/w_order_scheduler.sv
// W-bus scheduler: per-slave FIFOs of AW source masters; grants the W bus one whole burst at a time
// so each slave receives write data in the order its AWs were accepted.
module w_order_scheduler #(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int LOG_M = (M > 1) ? $clog2(M) : 1,
  parameter int LOG_N = (N > 1) ? $clog2(N) : 1,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  w_order_scheduler_if.slave bus,
  output logic               o_dbg_state,
  output logic [LOG_N-1:0]   o_dbg_rr_ptr,
  output logic [N*CW-1:0]    o_dbg_count
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t           r_state;
  logic [LOG_M-1:0] r_mem    [N][DEPTH];
  logic [PW-1:0]    r_wr_ptr [N];
  logic [PW-1:0]    r_rd_ptr [N];
  logic [CW-1:0]    r_count  [N];
  logic [LOG_N-1:0] r_rr_ptr;
  logic [M-1:0]     r_grant;
  logic [LOG_M-1:0] r_src;
  logic [LOG_N-1:0] r_dst;
  logic             r_busy;
  logic             r_err;

  logic [N-1:0]     w_full;
  logic [N-1:0]     w_push;
  logic [N-1:0]     w_pop_vec;
  logic [N-1:0]     w_elig;
  logic [LOG_M-1:0] w_head [N];
  logic             w_pop;
  logic             w_push_ok;
  logic             w_found;
  logic [LOG_N-1:0] w_pick_slv;
  logic [LOG_M-1:0] w_pick_mst;

  always_comb begin
    w_full     = '0;
    w_push     = '0;
    w_pop_vec  = '0;
    w_elig     = '0;
    w_head     = '{default: '0};
    w_found    = 1'b0;
    w_pick_slv = '0;
    w_pick_mst = '0;
    w_pop      = (r_state == S_BURST) && bus.mst_wvalid_i[r_src] && bus.bus_wready_i
                 && bus.mst_wlast_i[r_src];
    for (int j = 0; j < N; j++) begin
      w_head[j]    = r_mem[j][r_rd_ptr[j]];
      w_full[j]    = (r_count[j] == CW'(DEPTH));
      // A slave is schedulable only when its oldest AW owner is presenting W aimed at it.
      w_elig[j]    = (r_count[j] != '0) && bus.mst_wvalid_i[w_head[j]]
                     && (bus.mst_wdst_i[int'(w_head[j])*LOG_N +: LOG_N] == LOG_N'(j));
      w_pop_vec[j] = w_pop && (r_dst == LOG_N'(j));
    end
    w_push_ok = bus.aw_fire_i && !w_full[bus.aw_dst_i];
    for (int j = 0; j < N; j++) begin
      w_push[j] = w_push_ok && (bus.aw_dst_i == LOG_N'(j));
    end
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_elig[(int'(r_rr_ptr) + k) % N]) begin
        w_found    = 1'b1;
        w_pick_slv = LOG_N'((int'(r_rr_ptr) + k) % N);
        w_pick_mst = w_head[(int'(r_rr_ptr) + k) % N];
      end
    end
  end

  // Storage needs no reset: an entry is only read while its count is non-zero.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (w_push[j]) r_mem[j][r_wr_ptr[j]] <= bus.aw_src_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < N; j++) begin
        r_wr_ptr[j] <= '0;
        r_rd_ptr[j] <= '0;
        r_count[j]  <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (w_push[j])    r_wr_ptr[j] <= r_wr_ptr[j] + PW'(1);
        if (w_pop_vec[j]) r_rd_ptr[j] <= r_rd_ptr[j] + PW'(1);
        case ({w_push[j], w_pop_vec[j]})
          2'b10:   r_count[j] <= r_count[j] + CW'(1);
          2'b01:   r_count[j] <= r_count[j] - CW'(1);
          default: r_count[j] <= r_count[j];
        endcase
      end
      // Fullness is judged before any same-cycle pop, so this still flags a push racing a pop.
      if (bus.aw_fire_i && w_full[bus.aw_dst_i]) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= M'(1) << w_pick_mst;
            r_src   <= w_pick_mst;
            r_dst   <= w_pick_slv;
            r_busy  <= 1'b1;
            r_state <= S_BURST;
          end else begin
            r_grant <= '0;
          end
        end
        S_BURST: begin
          if (w_pop) begin
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= LOG_N'((int'(r_dst) + 1) % N);
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.aw_full_o = w_full;
  assign bus.w_grant_o = r_grant;
  assign bus.w_src_o   = r_src;
  assign bus.w_dst_o   = r_dst;
  assign bus.w_busy_o  = r_busy;
  assign bus.err_o     = r_err;
  assign o_dbg_state   = r_state;
  assign o_dbg_rr_ptr  = r_rr_ptr;

  always_comb begin
    o_dbg_count = '0;
    for (int j = 0; j < N; j++) o_dbg_count[j*CW +: CW] = r_count[j];
  end

endmodule

// File: tb/tb_w_order_scheduler.sv
// Bench for w_order_scheduler: directed scenarios plus a long random run against a queue-based reference model.
module tb_w_order_scheduler;
  localparam int M = 2, N = 2, DEPTH = 4, LOG_M = 1, LOG_N = 1, CW = 3;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic               dbg_state;
  logic [LOG_N-1:0]   dbg_rr;
  logic [N*CW-1:0]    dbg_count;

  w_order_scheduler_if #(.M(M), .N(N), .LOG_M(LOG_M), .LOG_N(LOG_N)) bus ();

  w_order_scheduler #(.M(M), .N(N), .DEPTH(DEPTH), .LOG_M(LOG_M), .LOG_N(LOG_N)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .o_dbg_state(dbg_state), .o_dbg_rr_ptr(dbg_rr), .o_dbg_count(dbg_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: one queue of owning masters per slave
  int           mq[N][$];
  bit           m_busy, m_err;
  int           m_src, m_dst, m_rr;
  logic [M-1:0] m_grant;

  // scoreboard: expected master order of bursts into slave 0
  logic [LOG_M-1:0] exp_q[$];

  function automatic int cnt(int j);
    return int'(dbg_count[j*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) mq[j].delete();
    m_busy = 0; m_err = 0; m_src = 0; m_dst = 0; m_rr = 0; m_grant = '0;
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_clock();
    int pick, pick_h, h, d;
    pick = -1; pick_h = 0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (pick < 0 && mq[j].size() > 0) begin
          h = mq[j][0];
          if (bus.mst_wvalid_i[h] && int'(bus.mst_wdst_i[h*LOG_N +: LOG_N]) == j) begin
            pick = j; pick_h = h;
          end
        end
      end
    end
    if (bus.aw_fire_i) begin
      d = int'(bus.aw_dst_i);
      if (mq[d].size() == DEPTH) m_err = 1;
      else mq[d].push_back(int'(bus.aw_src_i));
    end
    if (m_busy) begin
      if (bus.mst_wvalid_i[m_src] && bus.bus_wready_i && bus.mst_wlast_i[m_src]) begin
        void'(mq[m_dst].pop_front());
        m_busy = 0; m_grant = '0; m_rr = (m_dst + 1) % N;
      end
    end else if (pick >= 0) begin
      m_src = pick_h; m_dst = pick; m_busy = 1; m_grant = M'(1) << pick_h;
    end else begin
      m_grant = '0;
    end
  endtask

  // driver tasks
  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.aw_fire_i = 0; bus.aw_src_i = '0; bus.aw_dst_i = '0;
    bus.mst_wvalid_i = '0; bus.mst_wdst_i = '0; bus.mst_wlast_i = '0; bus.bus_wready_i = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstn = 0;
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1;
  endtask

  task automatic do_aw(input int src, input int dst);
    bus.aw_fire_i = 1; bus.aw_src_i = LOG_M'(src); bus.aw_dst_i = LOG_N'(dst);
    tick();
    bus.aw_fire_i = 0;
  endtask

  task automatic set_w(input int m, input bit v, input int d, input bit l);
    bus.mst_wvalid_i[m] = v;
    bus.mst_wdst_i[m*LOG_N +: LOG_N] = LOG_N'(d);
    bus.mst_wlast_i[m] = l;
  endtask

  task automatic test_reset();
    rstn = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      bus.aw_fire_i = 1'($urandom_range(0, 1)); bus.aw_src_i = 1'($urandom_range(0, 1));
      bus.aw_dst_i = 1'($urandom_range(0, 1)); bus.mst_wvalid_i = 2'($urandom_range(0, 3));
      bus.mst_wdst_i = 2'($urandom_range(0, 3)); bus.mst_wlast_i = 2'($urandom_range(0, 3));
      bus.bus_wready_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.w_grant_o !== 2'b00 || bus.w_busy_o !== 1'b0)
        $display("FAIL reset_grant_busy got=%b/%b exp=00/0", bus.w_grant_o, bus.w_busy_o);
      else n_pass++;
    end
    n_checks++;
    if ({bus.w_src_o, bus.w_dst_o, bus.err_o, bus.aw_full_o} !== 5'b0)
      $display("FAIL reset_misc got src=%0d dst=%0d err=%b full=%b exp all 0",
               bus.w_src_o, bus.w_dst_o, bus.err_o, bus.aw_full_o);
    else n_pass++;
    n_checks++;
    if (dbg_count !== '0) $display("FAIL reset_count got=%h exp=0", dbg_count);
    else n_pass++;
    clear_inputs();
    rstn = 1;
    for (int i = 0; i < 5; i++) begin
      bus.mst_wvalid_i = 2'($urandom_range(0, 3)); bus.mst_wdst_i = 2'($urandom_range(0, 3));
      bus.bus_wready_i = 1;
      tick();
      n_checks++;
      if (bus.w_grant_o !== 2'b00) $display("FAIL post_reset_grant got=%b exp=00", bus.w_grant_o);
      else n_pass++;
    end
  endtask

  task automatic test_ordering();
    logic [LOG_M-1:0] exp_src;
    apply_reset();
    exp_q.delete();
    do_aw(1, 0); exp_q.push_back(1'b1);
    do_aw(0, 0); exp_q.push_back(1'b0);
    set_w(0, 1, 0, 0); set_w(1, 1, 0, 0); bus.bus_wready_i = 1;
    tick();
    n_checks++;
    exp_src = exp_q.pop_front();
    if (bus.w_grant_o !== 2'b10 || bus.w_src_o !== exp_src || bus.w_dst_o !== 1'b0)
      $display("FAIL order_first got grant=%b src=%0d dst=%0d exp grant=10 src=%0d dst=0",
               bus.w_grant_o, bus.w_src_o, bus.w_dst_o, exp_src);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.w_grant_o !== 2'b10) $display("FAIL order_hold got=%b exp=10", bus.w_grant_o);
    else n_pass++;
    set_w(1, 1, 0, 1);
    tick();
    set_w(1, 0, 0, 0);
    n_checks++;
    if (bus.w_grant_o !== 2'b00 || bus.w_busy_o !== 1'b0)
      $display("FAIL order_gap got grant=%b busy=%b exp=00/0", bus.w_grant_o, bus.w_busy_o);
    else n_pass++;
    tick();
    n_checks++;
    exp_src = exp_q.pop_front();
    if (bus.w_grant_o !== 2'b01 || bus.w_src_o !== exp_src)
      $display("FAIL order_second got grant=%b src=%0d exp grant=01 src=%0d",
               bus.w_grant_o, bus.w_src_o, exp_src);
    else n_pass++;
    tick();
    set_w(0, 1, 0, 1);
    tick();
    set_w(0, 0, 0, 0);
    n_checks++;
    if (bus.w_grant_o !== 2'b00 || cnt(0) !== 0)
      $display("FAIL order_done got grant=%b cnt0=%0d exp 00/0", bus.w_grant_o, cnt(0));
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] eg[8];
    int         er[8];
    eg = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    er = '{0, 1, 1, 0, 0, 1, 1, 0};
    apply_reset();
    do_aw(0, 0); do_aw(1, 1); do_aw(0, 0); do_aw(1, 1);
    set_w(0, 1, 0, 1); set_w(1, 1, 1, 1); bus.bus_wready_i = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (bus.w_grant_o !== eg[i] || int'(dbg_rr) !== er[i])
        $display("FAIL rr_cycle%0d got grant=%b rr=%0d exp grant=%b rr=%0d",
                 i, bus.w_grant_o, dbg_rr, eg[i], er[i]);
      else n_pass++;
    end
    clear_inputs();
    n_checks++;
    if (cnt(0) !== 0 || cnt(1) !== 0)
      $display("FAIL rr_drained got cnt0=%0d cnt1=%0d exp 0/0", cnt(0), cnt(1));
    else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    do_aw(0, 1); do_aw(0, 1);
    set_w(0, 1, 1, 0); bus.bus_wready_i = 1;
    tick();
    for (int c = 0; c < 6; c++) begin
      bus.bus_wready_i = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      bus.mst_wlast_i[0] = (c == 5);
      n_checks++;
      if (bus.w_grant_o !== 2'b01 || cnt(1) !== 2)
        $display("FAIL bp_hold%0d got grant=%b cnt1=%0d exp 01/2", c, bus.w_grant_o, cnt(1));
      else n_pass++;
      tick();
    end
    set_w(0, 0, 0, 0);
    n_checks++;
    if (bus.w_grant_o !== 2'b00 || cnt(1) !== 1)
      $display("FAIL bp_end got grant=%b cnt1=%0d exp 00/1", bus.w_grant_o, cnt(1));
    else n_pass++;
  endtask

  task automatic test_full_error();
    int s[4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      s[i] = $urandom_range(0, 1);
      do_aw(s[i], 1);
    end
    n_checks++;
    if (bus.aw_full_o !== 2'b10 || cnt(1) !== 4 || bus.err_o !== 1'b0)
      $display("FAIL full_set got full=%b cnt1=%0d err=%b exp 10/4/0", bus.aw_full_o, cnt(1), bus.err_o);
    else n_pass++;
    do_aw($urandom_range(0, 1), 1);
    n_checks++;
    if (bus.err_o !== 1'b1 || cnt(1) !== 4)
      $display("FAIL full_overflow got err=%b cnt1=%0d exp 1/4", bus.err_o, cnt(1));
    else n_pass++;
    set_w(s[0], 1, 1, 1); bus.bus_wready_i = 1;
    tick();
    tick();
    set_w(s[0], 0, 0, 0);
    n_checks++;
    if (cnt(1) !== 3 || bus.aw_full_o !== 2'b00)
      $display("FAIL full_pop got cnt1=%0d full=%b exp 3/00", cnt(1), bus.aw_full_o);
    else n_pass++;
    set_w(s[1], 1, 1, 1);
    tick();
    bus.aw_fire_i = 1; bus.aw_src_i = 1'($urandom_range(0, 1)); bus.aw_dst_i = 1'b1;
    tick();
    bus.aw_fire_i = 0;
    set_w(s[1], 0, 0, 0);
    n_checks++;
    if (cnt(1) !== 3 || bus.err_o !== 1'b1 || bus.w_grant_o !== 2'b00)
      $display("FAIL push_pop got cnt1=%0d err=%b grant=%b exp 3/1/00", cnt(1), bus.err_o, bus.w_grant_o);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) do_aw(0, 1);
    do_aw(1, 0);
    set_w(1, 1, 0, 0); bus.bus_wready_i = 1;
    tick();
    tick();
    n_checks++;
    if (bus.w_grant_o !== 2'b10 || bus.err_o !== 1'b1)
      $display("FAIL midrst_pre got grant=%b err=%b exp 10/1", bus.w_grant_o, bus.err_o);
    else n_pass++;
    #2 rstn = 0;
    #1;
    n_checks++;
    if (bus.w_grant_o !== 2'b00 || bus.w_busy_o !== 1'b0 || bus.err_o !== 1'b0 ||
        dbg_count !== '0 || bus.aw_full_o !== 2'b00)
      $display("FAIL midrst_clear got grant=%b busy=%b err=%b cnt=%h full=%b exp all 0",
               bus.w_grant_o, bus.w_busy_o, bus.err_o, dbg_count, bus.aw_full_o);
    else n_pass++;
    model_reset();
    clear_inputs();
    #1 rstn = 1;
    set_w(1, 1, 0, 0); bus.bus_wready_i = 1;
    tick();
    set_w(1, 0, 0, 0);
    n_checks++;
    if (bus.w_grant_o !== 2'b00) $display("FAIL midrst_after got grant=%b exp=00", bus.w_grant_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] mfull;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) apply_reset();
      bus.aw_fire_i    = ($urandom_range(0, 2) == 0);
      bus.aw_src_i     = 1'($urandom_range(0, 1));
      bus.aw_dst_i     = 1'($urandom_range(0, 1));
      bus.mst_wvalid_i = 2'($urandom_range(0, 3));
      bus.mst_wdst_i   = 2'($urandom_range(0, 3));
      bus.mst_wlast_i  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      bus.bus_wready_i = ($urandom_range(0, 3) != 0);
      tick();
      for (int j = 0; j < N; j++) mfull[j] = (mq[j].size() == DEPTH);
      n_checks++;
      if (bus.w_grant_o !== m_grant || bus.w_busy_o !== m_busy)
        $display("FAIL rnd_grant c%0d got=%b/%b exp=%b/%b", i, bus.w_grant_o, bus.w_busy_o, m_grant, m_busy);
      else n_pass++;
      n_checks++;
      if (int'(bus.w_src_o) !== m_src || int'(bus.w_dst_o) !== m_dst)
        $display("FAIL rnd_srcdst c%0d got=%0d/%0d exp=%0d/%0d", i, bus.w_src_o, bus.w_dst_o, m_src, m_dst);
      else n_pass++;
      n_checks++;
      if (bus.err_o !== m_err || bus.aw_full_o !== mfull)
        $display("FAIL rnd_errfull c%0d got=%b/%b exp=%b/%b", i, bus.err_o, bus.aw_full_o, m_err, mfull);
      else n_pass++;
      n_checks++;
      if (cnt(0) !== mq[0].size() || cnt(1) !== mq[1].size() || int'(dbg_rr) !== m_rr)
        $display("FAIL rnd_cnt c%0d got=%0d/%0d rr=%0d exp=%0d/%0d rr=%0d", i, cnt(0), cnt(1), dbg_rr,
                 mq[0].size(), mq[1].size(), m_rr);
      else n_pass++;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ordering();
    test_round_robin();
    test_backpressure();
    test_full_error();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
